// File: rtl/validador_senha_pkg.sv
// Shared types and constants for the password validator: packed BCD password,
// the empty-slot marker, slot indices and the sequencer state encoding.
package validador_senha_pkg;

    typedef logic [19:0][3:0] senhaPac_t;

    localparam senhaPac_t SENHA_VAZIA = {20{4'hF}};

    localparam logic [2:0] SLOT_MASTER = 3'd0;
    localparam logic [2:0] SLOT_U1     = 3'd1;
    localparam logic [2:0] SLOT_U2     = 3'd2;
    localparam logic [2:0] SLOT_U3     = 3'd3;
    localparam logic [2:0] SLOT_U4     = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_RESULT = 2'd2,
        ST_BLOQ   = 2'd3
    } estado_t;

    function automatic logic senha_vazia(input senhaPac_t s);
        return (s == SENHA_VAZIA);
    endfunction

endpackage

// File: rtl/validador_senha_contador_bloqueio.sv
// Lockout timer: loadable 8-bit down-counter advanced by the 1 s tick.
// Owns the remaining lockout time and the lockout-active flag.
module contador_bloqueio (
    input  logic       clk,
    input  logic       rst,
    input  logic       carga,
    input  logic [7:0] valor,
    input  logic       tick,
    output logic [7:0] contagem,
    output logic       ativo,
    output logic       zero,
    output logic       expira
);

    logic [7:0] contagem_q;
    logic [7:0] contagem_d;
    logic       ativo_q;
    logic       ativo_d;

    // Next count: load has priority; ticks only count while the lockout is active.
    always_comb begin
        contagem_d = contagem_q;
        ativo_d    = ativo_q;
        if (carga) begin
            contagem_d = valor;
            ativo_d    = 1'b1;
        end else if (tick && ativo_q && (contagem_q != 8'd0)) begin
            contagem_d = contagem_q - 8'd1;
            ativo_d    = (contagem_q != 8'd1);
        end else begin
            contagem_d = contagem_q;
            ativo_d    = ativo_q;
        end
    end

    // Counter state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            contagem_q <= 8'd0;
            ativo_q    <= 1'b0;
        end else begin
            contagem_q <= contagem_d;
            ativo_q    <= ativo_d;
        end
    end

    assign contagem = contagem_q;
    assign ativo    = ativo_q;
    assign zero     = (contagem_q == 8'd0);
    assign expira   = tick & ativo_q & (contagem_q == 8'd1) & ~carga;

endmodule

// File: rtl/validador_senha.sv
// Password validator: scans the master and four user slots one per cycle,
// counts consecutive failures and enforces a timed lockout.
module validador_senha
    import validador_senha_pkg::*;
#(
    parameter int N_TENTATIVAS = 5,
    parameter int T_BLOQUEIO   = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [79:0] senha_in,
    input  logic        tick_1s,
    output logic [2:0]  slot_addr,
    input  logic [79:0] slot_data,
    output logic        busy,
    output logic        done,
    output logic        match,
    output logic        match_master,
    output logic [2:0]  match_idx,
    output logic        bloqueado,
    output logic [7:0]  tempo_restante,
    output logic [2:0]  tentativas
);

    localparam logic [2:0] LIMITE_TENT = 3'(N_TENTATIVAS);
    localparam logic [7:0] TEMPO_BLOQ  = 8'(T_BLOQUEIO);

    estado_t    estado_q, estado_d;
    senhaPac_t  senha_q, senha_d;
    logic [2:0] slot_addr_q, slot_addr_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       match_q, match_d;
    logic       match_master_q, match_master_d;
    logic [2:0] match_idx_q, match_idx_d;
    logic [2:0] tentativas_q, tentativas_d;
    logic       real_q, real_d;

    logic       igual_s;
    logic [2:0] tent_inc_s;
    logic       carga_s;
    logic       expira_s;
    logic       zero_s;
    logic       ativo_s;
    logic [7:0] contagem_s;

    // Empty slots hold all-F and must never match, whatever was captured.
    assign igual_s    = (senhaPac_t'(slot_data) == senha_q) && !senha_vazia(senhaPac_t'(slot_data));
    assign tent_inc_s = (tentativas_q >= LIMITE_TENT) ? LIMITE_TENT : (tentativas_q + 3'd1);

    contador_bloqueio u_contador (
        .clk      (clk),
        .rst      (rst),
        .carga    (carga_s),
        .valor    (TEMPO_BLOQ),
        .tick     (tick_1s),
        .contagem (contagem_s),
        .ativo    (ativo_s),
        .zero     (zero_s),
        .expira   (expira_s)
    );

    // Sequencer next-state and registered-output computation.
    always_comb begin
        estado_d       = estado_q;
        senha_d        = senha_q;
        slot_addr_d    = slot_addr_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
        match_d        = match_q;
        match_master_d = match_master_q;
        match_idx_d    = match_idx_q;
        tentativas_d   = tentativas_q;
        real_d         = real_q;
        carga_s        = 1'b0;
        case (estado_q)
            ST_IDLE: begin
                if (start) begin
                    senha_d        = senhaPac_t'(senha_in);
                    match_d        = 1'b0;
                    match_master_d = 1'b0;
                    match_idx_d    = SLOT_MASTER;
                    slot_addr_d    = SLOT_MASTER;
                    if (senha_vazia(senhaPac_t'(senha_in))) begin
                        estado_d = ST_RESULT;
                        busy_d   = 1'b0;
                        real_d   = 1'b0;
                    end else begin
                        estado_d = ST_SCAN;
                        busy_d   = 1'b1;
                        real_d   = 1'b1;
                    end
                end else begin
                    estado_d = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (igual_s) begin
                    match_d        = 1'b1;
                    match_idx_d    = slot_addr_q;
                    match_master_d = (slot_addr_q == SLOT_MASTER);
                    estado_d       = ST_RESULT;
                    busy_d         = 1'b0;
                    slot_addr_d    = SLOT_MASTER;
                end else if (slot_addr_q == SLOT_U4) begin
                    estado_d    = ST_RESULT;
                    busy_d      = 1'b0;
                    slot_addr_d = SLOT_MASTER;
                end else begin
                    slot_addr_d = slot_addr_q + 3'd1;
                end
            end
            ST_RESULT: begin
                done_d      = 1'b1;
                busy_d      = 1'b0;
                slot_addr_d = SLOT_MASTER;
                estado_d    = ST_IDLE;
                if (match_q) begin
                    tentativas_d = 3'd0;
                end else if (real_q) begin
                    tentativas_d = tent_inc_s;
                    if (tent_inc_s == LIMITE_TENT) begin
                        estado_d = ST_BLOQ;
                        carga_s  = 1'b1;
                    end else begin
                        estado_d = ST_IDLE;
                    end
                end else begin
                    tentativas_d = tentativas_q;
                end
            end
            ST_BLOQ: begin
                if (expira_s) begin
                    tentativas_d = 3'd0;
                    estado_d     = ST_IDLE;
                end else begin
                    estado_d = ST_BLOQ;
                end
            end
            default: begin
                estado_d    = ST_IDLE;
                busy_d      = 1'b0;
                slot_addr_d = SLOT_MASTER;
            end
        endcase
    end

    // Sequencer state and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q       <= ST_IDLE;
            senha_q        <= SENHA_VAZIA;
            slot_addr_q    <= 3'd0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            match_q        <= 1'b0;
            match_master_q <= 1'b0;
            match_idx_q    <= 3'd0;
            tentativas_q   <= 3'd0;
            real_q         <= 1'b0;
        end else begin
            estado_q       <= estado_d;
            senha_q        <= senha_d;
            slot_addr_q    <= slot_addr_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            match_q        <= match_d;
            match_master_q <= match_master_d;
            match_idx_q    <= match_idx_d;
            tentativas_q   <= tentativas_d;
            real_q         <= real_d;
        end
    end

    assign slot_addr      = slot_addr_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign match          = match_q;
    assign match_master   = match_master_q;
    assign match_idx      = match_idx_q;
    assign tentativas     = tentativas_q;
    assign bloqueado      = ativo_s;
    assign tempo_restante = contagem_s;

endmodule

// File: tb/tb_validador_senha.sv
// Scoreboard bench for validador_senha: stimulus pushes expected results,
// a monitor pops and compares them whenever done is observed.
module tb_validador_senha;
    import validador_senha_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [79:0] senha_in;
    logic        tick_1s;
    logic [2:0]  slot_addr;
    logic [79:0] slot_data;
    logic        busy, done, match, match_master, bloqueado;
    logic [2:0]  match_idx, tentativas;
    logic [7:0]  tempo_restante;

    logic [79:0] slots [0:7];

    typedef struct {
        logic       m;
        logic       mm;
        logic [2:0] idx;
        logic [2:0] tent;
        logic       bl;
        logic [7:0] tr;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;

    always #5 clk = ~clk;

    always_comb slot_data = slots[slot_addr];

    validador_senha #(.N_TENTATIVAS(5), .T_BLOQUEIO(30)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .senha_in       (senha_in),
        .tick_1s        (tick_1s),
        .slot_addr      (slot_addr),
        .slot_data      (slot_data),
        .busy           (busy),
        .done           (done),
        .match          (match),
        .match_master   (match_master),
        .match_idx      (match_idx),
        .bloqueado      (bloqueado),
        .tempo_restante (tempo_restante),
        .tentativas     (tentativas)
    );

    function automatic logic [79:0] pw(input logic [15:0] d);
        logic [79:0] r;
        r = {80{1'b1}};
        r[15:0] = d;
        return r;
    endfunction

    function automatic exp_t mk(input logic m, input logic mm, input logic [2:0] idx,
                                input logic [2:0] tent, input logic bl, input logic [7:0] tr);
        exp_t e;
        e.m = m; e.mm = mm; e.idx = idx; e.tent = tent; e.bl = bl; e.tr = tr; e.cyc = 0;
        return e;
    endfunction

    task automatic chk(input string nm, input int act, input int expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_busy"}, int'(busy), 0);
        chk({nm, "_done"}, int'(done), 0);
        chk({nm, "_match"}, int'(match), 0);
        chk({nm, "_master"}, int'(match_master), 0);
        chk({nm, "_idx"}, int'(match_idx), 0);
        chk({nm, "_bloq"}, int'(bloqueado), 0);
        chk({nm, "_tempo"}, int'(tempo_restante), 0);
        chk({nm, "_tent"}, int'(tentativas), 0);
        chk({nm, "_addr"}, int'(slot_addr), 0);
    endtask

    // Drive a one-cycle start; optionally register the expected result with its done cycle.
    task automatic issue(input logic [79:0] s, input bit push, input exp_t e, input int lat);
        @(negedge clk);
        start = 1'b1;
        senha_in = s;
        if (push) begin
            e.cyc = cyc + 1 + lat;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL done_timeout: got no done, expected %0d pending results", sb.size());
            sb.delete();
        end
    endtask

    task automatic tick();
        @(negedge clk);
        tick_1s = 1'b1;
        @(negedge clk);
        tick_1s = 1'b0;
    endtask

    // Monitor: compare every done pulse against the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1 expected done=0 (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    chk("done_cycle", cyc, e.cyc);
                    chk("match", int'(match), int'(e.m));
                    chk("match_master", int'(match_master), int'(e.mm));
                    chk("match_idx", int'(match_idx), int'(e.idx));
                    chk("tentativas", int'(tentativas), int'(e.tent));
                    chk("bloqueado", int'(bloqueado), int'(e.bl));
                    chk("tempo_restante", int'(tempo_restante), int'(e.tr));
                    chk("busy_at_done", int'(busy), 0);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        start = 1'b0;
        tick_1s = 1'b0;
        senha_in = {80{1'b1}};
        for (int i = 0; i < 8; i++) slots[i] = {80{1'b1}};
        slots[0] = pw(16'h1234);
        slots[3] = pw(16'h5678);
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Master match.
        issue(pw(16'h1234), 1'b1, mk(1'b1, 1'b1, 3'd0, 3'd0, 1'b0, 8'd0), 2);
        wait_done();

        // User slot 3 match, tracing the scan addresses.
        issue(pw(16'h5678), 1'b1, mk(1'b1, 1'b0, 3'd3, 3'd0, 1'b0, 8'd0), 5);
        chk("scan_addr0", int'(slot_addr), 0);
        chk("scan_busy", int'(busy), 1);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
            chk("scan_addr", int'(slot_addr), k);
        end
        wait_done();

        // Five wrong attempts lead to lockout.
        for (int n = 1; n <= 4; n++) begin
            issue(pw(16'h9999), 1'b1, mk(1'b0, 1'b0, 3'd0, 3'(n), 1'b0, 8'd0), 6);
            wait_done();
        end
        issue(pw(16'h9999), 1'b1, mk(1'b0, 1'b0, 3'd0, 3'd5, 1'b1, 8'd30), 6);
        wait_done();

        // start is ignored during lockout.
        issue(pw(16'h1234), 1'b0, mk(1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 8'd0), 0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("bloq_no_busy", int'(busy), 0);
        end
        chk("bloq_tempo_hold", int'(tempo_restante), 30);

        for (int i = 0; i < 29; i++) tick();
        #1;
        chk("bloq_tempo_1", int'(tempo_restante), 1);
        chk("bloq_still", int'(bloqueado), 1);
        chk("bloq_tent", int'(tentativas), 5);
        tick();
        #1;
        chk("unlock_bloq", int'(bloqueado), 0);
        chk("unlock_tempo", int'(tempo_restante), 0);
        chk("unlock_tent", int'(tentativas), 0);

        // Correct password after unlock, with tick_1s held during the scan.
        issue(pw(16'h1234), 1'b1, mk(1'b1, 1'b1, 3'd0, 3'd0, 1'b0, 8'd0), 2);
        wait_done();
        @(negedge clk);
        tick_1s = 1'b1;
        issue(pw(16'h5678), 1'b1, mk(1'b1, 1'b0, 3'd3, 3'd0, 1'b0, 8'd0), 5);
        wait_done();
        tick_1s = 1'b0;

        // All-F input: short path, attempt not counted.
        issue(pw(16'h4321), 1'b1, mk(1'b0, 1'b0, 3'd0, 3'd1, 1'b0, 8'd0), 6);
        wait_done();
        issue({80{1'b1}}, 1'b1, mk(1'b0, 1'b0, 3'd0, 3'd1, 1'b0, 8'd0), 1);
        wait_done();

        // Asynchronous reset in mid-scan.
        issue(pw(16'h9999), 1'b0, mk(1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 8'd0), 0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("midscan_addr", int'(slot_addr), 2);
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("rst_scan");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        issue(pw(16'h9999), 1'b1, mk(1'b0, 1'b0, 3'd0, 3'd1, 1'b0, 8'd0), 6);
        wait_done();

        // Asynchronous reset in mid-lockout.
        for (int n = 2; n <= 4; n++) begin
            issue(pw(16'h9999), 1'b1, mk(1'b0, 1'b0, 3'd0, 3'(n), 1'b0, 8'd0), 6);
            wait_done();
        end
        issue(pw(16'h9999), 1'b1, mk(1'b0, 1'b0, 3'd0, 3'd5, 1'b1, 8'd30), 6);
        wait_done();
        for (int i = 0; i < 13; i++) tick();
        #1;
        chk("midbloq_tempo", int'(tempo_restante), 17);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk_all_zero("rst_bloq");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        issue(pw(16'h1234), 1'b1, mk(1'b1, 1'b1, 3'd0, 3'd0, 1'b0, 8'd0), 2);
        wait_done();

        repeat (3) @(posedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/validador_senha.md
Name: validador_senha

Overview:
- Sequencer that checks a typed password against the five stored password slots: master plus users 1-4.
- Reads one slot per cycle through a read port into the setup register bank, exiting early on the first match.
- Tracks consecutive failed attempts and enforces a timed lockout in 1-second ticks.
- Sits between the keypad digit packer and the operational FSM. The FSM pulses `start` and consumes `done` and the match outputs; the lockout countdown feeds the display.

Parameters:
- N_TENTATIVAS, 5, consecutive failed attempts that trigger a lockout (1..7).
- T_BLOQUEIO, 30, lockout duration in tick_1s periods (1..255).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to validate senha_in
- senha_in  in  80  typed password: 20 BCD digits, right-aligned, unused digits = 4'hF
- tick_1s  in  1  one-cycle pulse once per second
- slot_addr  out  3  slot being read (0 = master, 1..4 = user)
- slot_data  in  80  contents of slot_addr; combinational, valid in the same cycle
- busy  out  1  comparison scan in progress
- done  out  1  one-cycle pulse: result valid
- match  out  1  last attempt matched a slot
- match_master  out  1  last match was slot 0
- match_idx  out  3  slot that matched; 0 when no match
- bloqueado  out  1  lockout active
- tempo_restante  out  8  seconds of lockout remaining
- tentativas  out  3  current consecutive-failure count

Behaviour:
- Reset: all outputs and internal registers are 0; state is IDLE; the captured password is all-F.
- States:
  - IDLE: on start, capture senha_in.
    - If the captured value is all-F: go to RESULT with match=0 and do not count an attempt.
    - Otherwise: go to SCAN with slot_addr=0, busy=1, and clear match/match_master/match_idx.
  - SCAN: each edge compares slot_data with the captured password over all 80 bits.
    - A slot whose content is all-F is empty and never matches.
    - On equality: latch match=1, match_idx=slot_addr, match_master=(slot_addr==0), go to RESULT.
    - If there is no match and slot_addr==4: go to RESULT with match=0.
    - Otherwise: increment slot_addr.
  - RESULT (one cycle): done=1, busy=0, slot_addr returns to 0.
    - On match: tentativas<=0.
    - On failure from a real scan: tentativas<=tentativas+1.
    - If the incremented value equals N_TENTATIVAS: next state BLOQ, with bloqueado=1 and tempo_restante=T_BLOQUEIO loaded on that same edge.
    - Otherwise: next state IDLE.
  - BLOQ: start is ignored. Each tick_1s decrements tempo_restante. The tick that takes it from 1 to 0 also clears bloqueado and tentativas and returns to IDLE.
- Latency: start sampled at edge E0. A match at slot k gives done high in the cycle after edge E(k+2); no match gives done after E6. The all-F input gives done after E1.
- start is ignored while in SCAN, RESULT or BLOQ; it is never queued.
- match, match_master and match_idx hold their values until the next accepted start.
- tick_1s is ignored outside BLOQ.
- Asynchronous reset at any point, including mid-scan or mid-lockout, returns to the reset state immediately; no done pulse is emitted.
- tentativas saturates at N_TENTATIVAS and never wraps.

Decomposition:
- Shared package `Tipos.sv`:
  - senhaPac_t (20 x 4-bit digits)
  - SENHA_VAZIA constant (all 4'hF)
  - slot index constants SLOT_MASTER=0, SLOT_U1..SLOT_U4
  - the validador state enum
- One sub-module, `contador_bloqueio`: a loadable 8-bit down-counter with tick enable and a zero flag. It owns tempo_restante and bloqueado.

Test Plan:
- Slot0 = F..F1234, start with senha_in = F..F1234 -> done one cycle after E2; match=1, match_master=1, match_idx=0, tentativas=0.
- Slot3 = F..F5678, slots 1, 2 and 4 empty, start with F..F5678 -> slot_addr steps 0..3; done after E5; match_idx=3, match_master=0.
- Wrong password, 5 starts with N_TENTATIVAS=5 -> tentativas 1..4 with match=0. The 5th done coincides with bloqueado=1 and tempo_restante=30. After 30 tick_1s pulses: bloqueado=0, tentativas=0.
- Lockout: start during BLOQ -> no busy, no done. tick_1s during SCAN -> no effect. After unlocking, a correct password gives match=1.
- Input all-F with all user slots empty -> done after E1, match=0, tentativas unchanged. An empty user slot never matches all-F.
- rst asserted in mid-scan (slot_addr=2) and in mid-lockout (tempo_restante=17) -> all outputs 0 asynchronously. After release, the next start behaves as from reset.
